reg_alu_ctrl: RTL and testbench
===============================

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, datapath and command word width; DW >= 16 is required.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port cmd_valid  input  1  host command word valid.
REQ-005 SHALL have port cmd_ready  output  1  controller accepts a command word.
REQ-006 SHALL have port cmd_data  input  DW  instruction word or immediate word.
REQ-007 SHALL have ports sel, wr  output  1 each  datapath write-source select (1=ALU, 0=d_in) and register write enable.
REQ-008 SHALL have ports op  output  2, rd_addr_a, rd_addr_b, wr_addr  output  3 each  datapath ALU op and register addresses.
REQ-009 SHALL have port d_in  output  DW  immediate write data to datapath.
REQ-010 SHALL have ports d_out_a, d_out_b  input  DW each, cout  input  1  datapath read data and ALU carry.
REQ-011 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  2*DW  read response {d_out_a,d_out_b}.
REQ-012 SHALL have port carry_flag  output  1  carry captured from last ALU instruction.

Function
REQ-013 Instruction decode of cmd_data[15:0] SHALL be: [15:14] class (00 ALU, 01 LDI, 10 READ, 11 NOP), [13:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] ignored.
REQ-014 FSM states SHALL be IDLE, EXEC, IMM, WLD, RD, RSP; all datapath-side outputs registered.
REQ-015 IDLE: cmd_ready=1; handshake (cmd_valid&cmd_ready) latches instruction; ALU->EXEC, LDI->IMM, READ->RD, NOP->IDLE.
REQ-016 EXEC SHALL last exactly one cycle: sel=1, wr=1, op, rd_addr_a=ra, rd_addr_b=rb, wr_addr=rd; carry_flag<=cout at its closing edge; then IDLE.
REQ-017 IMM: cmd_ready=1; wait indefinitely for next handshake; latch cmd_data as immediate; then WLD.
REQ-018 WLD SHALL last exactly one cycle: sel=0, wr=1, wr_addr=rd, d_in=immediate; then IDLE.
REQ-019 RD SHALL last exactly one cycle: wr=0, rd_addr_a=ra, rd_addr_b=rb; rsp_data<={d_out_a,d_out_b} at its closing edge; then RSP.
REQ-020 RSP: rsp_valid=1, rsp_data held stable until rsp_valid&rsp_ready; then IDLE.
REQ-021 cmd_ready SHALL be 0 in EXEC, WLD, RD, RSP; rsp_valid SHALL be 1 only in RSP.
REQ-022 wr SHALL be 1 only in EXEC and WLD; exactly one datapath write per ALU or LDI instruction.
REQ-023 carry_flag SHALL change only at the end of EXEC; LDI, READ, NOP leave it unchanged.
REQ-024 rd equal to ra or rb SHALL be legal; source operands are the pre-write register values.
REQ-025 Outside EXEC/WLD/RD, op, addresses and d_in SHALL hold their last values; sel SHALL be 0.

Reset
REQ-026 reset low SHALL immediately force IDLE, wr=0, sel=0, op=0, all addresses 0, d_in=0, rsp_valid=0, rsp_data=0, carry_flag=0, cmd_ready=0.
REQ-027 cmd_ready SHALL rise only in the first cycle after reset deasserts; a reset during IMM, WLD, EXEC, RD or RSP SHALL abort with no write and no response.

Verification
REQ-028 Bench SHALL cover reset: assert reset mid-cycle -> all outputs at REQ-026 values without a clock edge.
REQ-029 Bench SHALL cover LDI: cmd 0x4600 then 0xCDEF -> one cycle wr=1, sel=0, wr_addr=3, d_in=0xCDEF; R3=0xCDEF.
REQ-030 Bench SHALL cover ALU: cmd 0x0468 -> one cycle sel=1, wr=1, op=00, rd_addr_a=1, rd_addr_b=5, wr_addr=2; cmd_ready=0 that cycle.
REQ-031 Bench SHALL cover carry with op 00 = add: R1=0xFFFF, R2=0x0001, cmd 0x0850 -> R4=0x0000, carry_flag=1.
REQ-032 Bench SHALL cover READ backpressure: cmd 0x80D0, rsp_ready low 3 cycles -> rsp_valid held, rsp_data={R3,R2} stable, cmd_ready=0 until handshake.
REQ-033 Bench SHALL cover reset mid-LDI: cmd 0x4600, reset pulse, then 0xCDEF -> no write; 0xCDEF decoded as class 11 NOP.

Source files
------------

// File: rtl/reg_alu_ctrl.sv
// Purpose: sequences host command words into register-file/ALU datapath writes and reads.
// Latency: ALU 1 cycle after accept, LDI 1 cycle after immediate, READ response 2 cycles after accept.
// Backpressure: cmd_ready low while busy; response held in RSP until rsp_ready.
module reg_alu_ctrl #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [DW-1:0]   cmd_data,
    output logic            sel,
    output logic            wr,
    output logic [1:0]      op,
    output logic [2:0]      rd_addr_a,
    output logic [2:0]      rd_addr_b,
    output logic [2:0]      wr_addr,
    output logic [DW-1:0]   d_in,
    input  logic [DW-1:0]   d_out_a,
    input  logic [DW-1:0]   d_out_b,
    input  logic            cout,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_data,
    output logic            carry_flag
);

    typedef enum logic [2:0] {IDLE, EXEC, IMM, WLD, RD, RSP} state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_READ = 2'b10;

    state_t          state, state_nxt;
    logic [2:0]      rd_q, rd_nxt;
    logic [1:0]      op_nxt;
    logic [2:0]      rd_addr_a_nxt, rd_addr_b_nxt, wr_addr_nxt;
    logic [DW-1:0]   d_in_nxt;
    logic [2*DW-1:0] rsp_data_nxt;
    logic            carry_nxt;
    logic            cmd_hs, rsp_hs;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign rsp_hs = rsp_valid & rsp_ready;

    // All datapath-facing outputs are registered from the next state, so they
    // are valid for the whole cycle of the state they belong to.
    always_comb begin
        state_nxt     = state;
        rd_nxt        = rd_q;
        op_nxt        = op;
        rd_addr_a_nxt = rd_addr_a;
        rd_addr_b_nxt = rd_addr_b;
        wr_addr_nxt   = wr_addr;
        d_in_nxt      = d_in;
        rsp_data_nxt  = rsp_data;
        carry_nxt     = carry_flag;

        case (state)
            IDLE: begin
                if (cmd_hs) begin
                    rd_nxt = cmd_data[11:9];
                    case (cmd_data[15:14])
                        CLS_ALU: begin
                            state_nxt     = EXEC;
                            op_nxt        = cmd_data[13:12];
                            wr_addr_nxt   = cmd_data[11:9];
                            rd_addr_a_nxt = cmd_data[8:6];
                            rd_addr_b_nxt = cmd_data[5:3];
                        end
                        CLS_LDI: state_nxt = IMM;
                        CLS_READ: begin
                            state_nxt     = RD;
                            rd_addr_a_nxt = cmd_data[8:6];
                            rd_addr_b_nxt = cmd_data[5:3];
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            EXEC: begin
                carry_nxt = cout;
                state_nxt = IDLE;
            end
            IMM: begin
                if (cmd_hs) begin
                    state_nxt   = WLD;
                    wr_addr_nxt = rd_q;
                    d_in_nxt    = cmd_data;
                end
            end
            WLD: state_nxt = IDLE;
            RD: begin
                rsp_data_nxt = {d_out_a, d_out_b};
                state_nxt    = RSP;
            end
            RSP: begin
                if (rsp_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_q       <= '0;
            cmd_ready  <= 1'b0;
            sel        <= 1'b0;
            wr         <= 1'b0;
            op         <= '0;
            rd_addr_a  <= '0;
            rd_addr_b  <= '0;
            wr_addr    <= '0;
            d_in       <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            carry_flag <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_q       <= rd_nxt;
            cmd_ready  <= (state_nxt == IDLE) || (state_nxt == IMM);
            sel        <= (state_nxt == EXEC);
            wr         <= (state_nxt == EXEC) || (state_nxt == WLD);
            op         <= op_nxt;
            rd_addr_a  <= rd_addr_a_nxt;
            rd_addr_b  <= rd_addr_b_nxt;
            wr_addr    <= wr_addr_nxt;
            d_in       <= d_in_nxt;
            rsp_valid  <= (state_nxt == RSP);
            rsp_data   <= rsp_data_nxt;
            carry_flag <= carry_nxt;
        end
    end

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Bench for reg_alu_ctrl: behavioural register file/ALU behind the controller,
// expected writes and responses queued at issue time and checked as the DUT emits them.
module tb_reg_alu_ctrl;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DW-1:0]   cmd_data;
    logic            sel, wr;
    logic [1:0]      op;
    logic [2:0]      rd_addr_a, rd_addr_b, wr_addr;
    logic [DW-1:0]   d_in, d_out_a, d_out_b;
    logic            cout;
    logic            rsp_valid, rsp_ready;
    logic [2*DW-1:0] rsp_data;
    logic            carry_flag;

    reg_alu_ctrl #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .sel(sel), .wr(wr), .op(op),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .wr_addr(wr_addr),
        .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b), .cout(cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    // Datapath: 8-entry register file, combinational reads, ALU with carry out.
    logic [DW-1:0] dp_regs [8];
    logic [DW:0]   alu_y;
    assign d_out_a = dp_regs[rd_addr_a];
    assign d_out_b = dp_regs[rd_addr_b];
    always_comb begin
        case (op)
            2'd0:    alu_y = {1'b0, d_out_a} + {1'b0, d_out_b};
            2'd1:    alu_y = {1'b0, d_out_a} - {1'b0, d_out_b};
            2'd2:    alu_y = {1'b0, d_out_a & d_out_b};
            default: alu_y = {1'b0, d_out_a ^ d_out_b};
        endcase
    end
    assign cout = alu_y[DW];
    always @(posedge clk) if (wr) dp_regs[wr_addr] <= sel ? alu_y[DW-1:0] : d_in;

    typedef struct {
        logic          sel;
        logic [2:0]    waddr;
        logic [DW-1:0] data;
        logic [2:0]    ra;
        logic [2:0]    rb;
    } wr_exp_t;

    wr_exp_t         wq [$];
    logic [2*DW-1:0] rq [$];
    logic [DW-1:0]   exp_regs [8];
    logic            exp_carry;
    int              n_vec = 0;
    int              n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: every write and every response must match the head of its queue.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (wr) begin
                chk("rdy_during_wr", cmd_ready, 0);
                if (wq.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_sel", sel, e.sel);
                    chk("wr_addr", wr_addr, e.waddr);
                    chk("wr_data", sel ? alu_y[DW-1:0] : d_in, e.data);
                    if (e.sel) begin
                        chk("wr_op", op, 0);
                        chk("wr_ra", rd_addr_a, e.ra);
                        chk("wr_rb", rd_addr_b, e.rb);
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) chk("unexpected_rsp", 1, 0);
                else chk("rsp_data", rsp_data, rq.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic [DW-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_data  = d;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
        if (!cmd_ready) chk("cmd_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
        if (!cmd_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_ldi(input logic [2:0] rd, input logic [DW-1:0] v);
        wr_exp_t e;
        e.sel = 1'b0; e.waddr = rd; e.data = v; e.ra = '0; e.rb = '0;
        wq.push_back(e);
        exp_regs[rd] = v;
        send_cmd(16'h4000 | (16'(rd) << 9));
        send_cmd(v);
        wait_idle();
        chk("carry_after_ldi", carry_flag, exp_carry);
    endtask

    task automatic do_alu(input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
        wr_exp_t     e;
        logic [DW:0] s;
        s = {1'b0, exp_regs[ra]} + {1'b0, exp_regs[rb]};
        e.sel = 1'b1; e.waddr = rd; e.data = s[DW-1:0]; e.ra = ra; e.rb = rb;
        wq.push_back(e);
        exp_regs[rd] = s[DW-1:0];
        exp_carry    = s[DW];
        send_cmd((16'(rd) << 9) | (16'(ra) << 6) | (16'(rb) << 3));
        wait_idle();
        chk("carry_after_alu", carry_flag, exp_carry);
    endtask

    task automatic do_read(input logic [2:0] ra, input logic [2:0] rb, input int stall);
        logic [2*DW-1:0] e;
        int n = 0;
        e = {exp_regs[ra], exp_regs[rb]};
        rq.push_back(e);
        send_cmd(16'h8000 | (16'(ra) << 6) | (16'(rb) << 3));
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        for (int i = 0; i < stall; i++) begin
            if (i > 0) @(negedge clk);
            chk("rsp_vld_hold", rsp_valid, 1);
            chk("rsp_dat_hold", rsp_data, e);
            chk("rdy_during_rsp", cmd_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        wait_idle();
        chk("carry_after_read", carry_flag, exp_carry);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, rsp_valid, carry_flag, cmd_ready}, 0);
        chk({tag, "_rsp"}, rsp_data, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            dp_regs[i]  = '0;
            exp_regs[i] = '0;
        end
        exp_carry = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        reset     = 1'b1;

        // Reset asserted mid-cycle, before any clock edge.
        #3 reset = 1'b0;
        #1 chk_reset_outputs("por_async");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b1;
        #1 chk("rdy_before_edge", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rdy_after_edge", cmd_ready, 1);

        do_ldi(3'd1, 16'hFFFF);
        do_ldi(3'd2, 16'h0001);
        do_ldi(3'd3, 16'hCDEF);          // 0x4600, 0xCDEF
        do_read(3'd3, 3'd2, 3);          // 0x80D0 with backpressure
        do_alu(3'd4, 3'd1, 3'd2);        // 0x0850: FFFF+0001 -> 0000, carry 1
        do_alu(3'd2, 3'd1, 3'd5);        // 0x0468
        do_alu(3'd1, 3'd1, 3'd1);        // rd == ra == rb
        send_cmd(16'hC000);              // NOP
        repeat (3) @(negedge clk);
        chk("carry_after_nop", carry_flag, exp_carry);
        do_read(3'd4, 3'd1, 0);
        do_ldi(3'd3, 16'h1234);

        // Reset while waiting for the LDI immediate.
        send_cmd(16'h4600);
        @(posedge clk); #2;
        reset = 1'b0;
        #1 chk_reset_outputs("mid_ldi_async");
        @(posedge clk); @(negedge clk);
        chk_reset_outputs("mid_ldi_held");
        exp_carry = 1'b0;
        #1 reset = 1'b1;
        #1 chk("rdy_before_edge2", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rdy_after_edge2", cmd_ready, 1);
        send_cmd(16'hCDEF);              // now decodes as NOP
        repeat (3) @(negedge clk);
        chk("carry_after_abort", carry_flag, 0);
        do_read(3'd3, 3'd2, 1);          // R3 must still hold 0x1234

        repeat (2) @(negedge clk);
        chk("wr_queue_empty", wq.size(), 0);
        chk("rsp_queue_empty", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
